display_decimal_seg: RTL and testbench



---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 14 +
 rtl/display_decimal_seg.sv | 112 +++++++++++
 tb/tb_display_decimal_seg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, FSM states and helpers for the decimal 7-segment display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; entry n is the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

    function automatic logic [3:0] add3(input logic [3:0] i_nib);
        return (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_nibble <= 4'd9) o_seg = SEG_DIGITS[i_nibble];
    end

endmodule

// File: rtl/display_decimal_seg.sv
// Sequential binary-to-decimal 7-segment driver using an iterative double-dabble engine,
// with valid/ready input, optional leading-zero blanking and overflow dashes.
module display_decimal_seg
    import seg7_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned DIGITS   = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   value,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  overflow,
    output logic                  done
);

    localparam int unsigned BW    = 4 * DIGITS;
    localparam int unsigned CW    = $clog2(IN_WIDTH + 1);
    localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

    state_e                r_state, w_state_next;
    logic [IN_WIDTH-1:0]   r_shift;
    logic [BW-1:0]         r_bcd, w_bcd_adj;
    logic [CW-1:0]         r_cnt;
    logic                  r_ovf_pend;
    logic [7*DIGITS-1:0]   r_seg, w_seg_next, w_dec;
    logic                  r_overflow, r_done;
    logic                  w_zero_above;

    assign in_ready = (r_state == IDLE);
    assign seg      = r_seg;
    assign overflow = r_overflow;
    assign done     = r_done;

    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_bcd_adj[4*i +: 4] = add3(r_bcd[4*i +: 4]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .i_nibble (r_bcd[4*g +: 4]),
            .o_seg    (w_dec[7*g +: 7])
        );
    end

    // Walk from the most significant digit down; digit 0 is never blanked.
    always_comb begin
        w_seg_next   = w_dec;
        w_zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_bcd[4*i +: 4] == 4'd0);
            if (BLANK_LZ && w_zero_above) w_seg_next[7*i +: 7] = SEG_BLANK;
        end
        if (r_ovf_pend) w_seg_next = {DIGITS{SEG_DASH}};
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == CW'(IN_WIDTH - 1)) w_state_next = UPDATE;
            UPDATE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_seg      <= {DIGITS{SEG_BLANK}};
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift    <= value;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (64'(value) >= LIMIT);
                    end
                end
                SHIFT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + CW'(1);
                end
                UPDATE: begin
                    r_seg      <= w_seg_next;
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_decimal_seg.sv
// Scoreboard bench: two instances (blanking on/off) share stimulus; a monitor per instance
// compares each done pulse against an arithmetic reference model.
module tb_display_decimal_seg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] value = '0;
    logic        rdy0, rdy1, ovf0, ovf1, done0, done1;
    logic [27:0] seg0, seg1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [27:0] seg;
        logic        ovf;
        int          acc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    display_decimal_seg #(.IN_WIDTH(16), .DIGITS(4), .BLANK_LZ(1'b1)) u_dut_lz (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (rdy0),
        .value    (value),
        .seg      (seg0),
        .overflow (ovf0),
        .done     (done0)
    );

    display_decimal_seg #(.IN_WIDTH(16), .DIGITS(4), .BLANK_LZ(1'b0)) u_dut_full (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (rdy1),
        .value    (value),
        .seg      (seg1),
        .overflow (ovf1),
        .done     (done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] model_seg(input int unsigned v, input bit blank);
        logic [27:0] s;
        int unsigned pw;
        pw = 1;
        for (int i = 0; i < 4; i++) begin
            if (v >= 10000)                       s[7*i +: 7] = 7'b0111111;
            else if (blank && i > 0 && v < pw)    s[7*i +: 7] = 7'b1111111;
            else                                  s[7*i +: 7] = digit_pat(int'((v / pw) % 10));
            pw = pw * 10;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                check("lz_unexpected_done", 64'(done0), 64'(0));
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("lz_seg", 64'(seg0), 64'(e.seg));
                check("lz_overflow", 64'(ovf0), 64'(e.ovf));
                check("lz_latency", 64'(cyc - e.acc), 64'(17));
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                check("full_unexpected_done", 64'(done1), 64'(0));
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("full_seg", 64'(seg1), 64'(e.seg));
                check("full_overflow", 64'(ovf1), 64'(e.ovf));
                check("full_latency", 64'(cyc - e.acc), 64'(17));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input int unsigned v);
        int guard;
        exp_t e;
        guard = 0;
        while (!rdy0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rdy0) check("ready_timeout", 64'(rdy0), 64'(1));
        in_valid = 1'b1;
        value    = 16'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        value    = 16'($urandom);
        e.ovf = (v >= 10000);
        e.acc = cyc;
        e.seg = model_seg(v, 1'b1);
        q0.push_back(e);
        e.seg = model_seg(v, 1'b0);
        q1.push_back(e);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !rdy0) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 64'(q0.size() + q1.size()), 64'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg_lz", 64'(seg0), 64'({4{7'b1111111}}));
        check("rst_seg_full", 64'(seg1), 64'({4{7'b1111111}}));
        check("rst_overflow", 64'({ovf0, ovf1}), 64'(0));
        check("rst_done", 64'({done0, done1}), 64'(0));
        check("rst_ready", 64'({rdy0, rdy1}), 64'(3));

        begin
            int unsigned dir[8] = '{1234, 0, 7, 9999, 10000, 65535, 10, 100};
            foreach (dir[k]) begin
                issue(dir[k]);
                wait_idle();
            end
        end

        // A request while busy must be dropped.
        issue(42);
        for (int k = 0; k <= 16; k++) begin
            check("busy_ready", 64'({rdy0, rdy1}), 64'(0));
            if (k == 4) begin
                in_valid = 1'b1;
                value    = 16'd99;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();
        repeat (20) @(posedge clk);
        #1;

        // Reset mid-conversion aborts without a result.
        issue(5555);
        wait_idle();
        issue(1234);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        void'(q0.pop_back());
        void'(q1.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_seg_lz", 64'(seg0), 64'({4{7'b1111111}}));
        check("abort_seg_full", 64'(seg1), 64'({4{7'b1111111}}));
        check("abort_overflow", 64'({ovf0, ovf1}), 64'(0));
        check("abort_ready", 64'({rdy0, rdy1}), 64'(3));
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done_seg", 64'(seg0), 64'({4{7'b1111111}}));
        issue(8);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            int unsigned v;
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 65535);
                1:       v = $urandom_range(0, 99);
                default: v = $urandom_range(0, 9999);
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            issue(v);
        end
        wait_idle();
        repeat (25) @(posedge clk);
        #1;
        check("final_queue", 64'(q0.size() + q1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
